// File: rtl/atmega_eep_arb.sv
// atmega_eep_arb
//   Arbiter and bulk sequencer for the ATmega EEPROM external port.
//   Two clients share the port:
//   - a single-byte host requester (debugger/ISP)
//   - a bulk engine that either dumps the whole array to a byte stream or
//     restores it from one
//   The AVR core is parked through hold_req/hold_ack before the port is
//   driven, and is released again once nothing is eligible.
//
// Parameters
//   EEP_SIZE : EEPROM size in bytes (legal addresses 0..EEP_SIZE-1)
//   CNT_W    : bulk address counter width, 2^CNT_W >= EEP_SIZE
//
// Optional feature macro
//   EEP_ARB_CRC_EN : when defined, bulk_crc carries a CRC-8 (poly 0x07,
//                    init 0x00) over every bulk byte transferred. When
//                    undefined, bulk_crc is tied to 0x00.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   host_req/we/addr/wdata         host request (held until host_ack)
//   host_rdata/ack/err             host completion (one-cycle ack pulse)
//   bulk_start/dir                 bulk job start pulse, 0=dump 1=restore
//   bulk_busy/done/crc             bulk job status
//   dump_data/valid/ready          dump output stream
//   load_data/valid/ready          restore input stream (ready = consume pulse)
//   hold_req/hold_ack              core park handshake
//   ext_eep_*                      EEPROM port
module atmega_eep_arb #(
  parameter int EEP_SIZE = 512,
  parameter int CNT_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [16:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        host_ack,
  output logic        host_err,
  input  logic        bulk_start,
  input  logic        bulk_dir,
  output logic        bulk_busy,
  output logic        bulk_done,
  output logic [7:0]  bulk_crc,
  output logic [7:0]  dump_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  input  logic [7:0]  load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        hold_req,
  input  logic        hold_ack,
  output logic [16:0] ext_eep_addr,
  output logic [7:0]  ext_eep_data_in,
  output logic        ext_eep_data_wr,
  output logic        ext_eep_data_rd,
  output logic        ext_eep_data_en,
  input  logic [7:0]  ext_eep_data_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_GRANT, S_RD1, S_RD2, S_WR, S_REL
  } state_t;

  state_t           state, state_nxt;

  logic             job_dir;        // direction latched at bulk_start
  logic [CNT_W-1:0] bulk_cnt;       // next bulk address to issue
  logic             last_issued;    // final bulk address already granted
  logic             serve_bulk;     // current port access belongs to bulk
  logic             last_was_bulk;  // round-robin memory; 1 after reset so host wins first

  logic             host_elig, dump_elig, load_elig, bulk_elig, host_oor;
  logic             pick_host, pick_bulk, sink_take;

  // A host whose ack is on the wire this cycle is still holding host_req
  // for the old transaction, so it must not be granted again.
  assign host_elig = host_req && !host_ack;
  assign dump_elig = bulk_busy && !job_dir && !last_issued && (!dump_valid || dump_ready);
  assign load_elig = bulk_busy && job_dir && !last_issued && load_valid;
  assign bulk_elig = dump_elig || load_elig;
  assign host_oor  = host_addr >= 17'(EEP_SIZE);

  assign pick_host = host_elig && (!bulk_elig || last_was_bulk);
  assign pick_bulk = bulk_elig && !pick_host;
  assign sink_take = dump_valid && dump_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    hold_req        = 1'b0;
    ext_eep_data_en = 1'b0;
    ext_eep_data_rd = 1'b0;
    ext_eep_data_wr = 1'b0;
    case (state)
      S_IDLE: begin
        if ((host_elig || bulk_elig) && !hold_ack) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        hold_req = 1'b1;
        if (hold_ack) state_nxt = S_GRANT;
      end
      S_GRANT: begin
        hold_req        = 1'b1;
        ext_eep_data_en = 1'b1;
        if (pick_host) begin
          // Out-of-range host requests are answered from GRANT without
          // touching the port.
          if (host_oor)     state_nxt = S_GRANT;
          else if (host_we) state_nxt = S_WR;
          else              state_nxt = S_RD1;
        end else if (pick_bulk) begin
          state_nxt = job_dir ? S_WR : S_RD1;
        end else begin
          state_nxt = S_REL;
        end
      end
      S_RD1: begin
        hold_req        = 1'b1;
        ext_eep_data_en = 1'b1;
        ext_eep_data_rd = 1'b1;
        state_nxt       = S_RD2;
      end
      S_RD2: begin
        hold_req        = 1'b1;
        ext_eep_data_en = 1'b1;
        ext_eep_data_rd = 1'b1;
        state_nxt       = S_GRANT;
      end
      S_WR: begin
        hold_req        = 1'b1;
        ext_eep_data_en = 1'b1;
        ext_eep_data_wr = 1'b1;
        state_nxt       = S_GRANT;
      end
      S_REL: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      host_rdata      <= 8'h00;
      host_ack        <= 1'b0;
      host_err        <= 1'b0;
      bulk_busy       <= 1'b0;
      bulk_done       <= 1'b0;
      dump_data       <= 8'h00;
      dump_valid      <= 1'b0;
      load_ready      <= 1'b0;
      ext_eep_addr    <= 17'h0;
      ext_eep_data_in <= 8'h00;
      job_dir         <= 1'b0;
      bulk_cnt        <= '0;
      last_issued     <= 1'b0;
      serve_bulk      <= 1'b0;
      last_was_bulk   <= 1'b1;
    end else begin
      host_ack   <= 1'b0;
      host_err   <= 1'b0;
      load_ready <= 1'b0;
      bulk_done  <= 1'b0;

      if (bulk_start && !bulk_busy) begin
        bulk_busy   <= 1'b1;
        job_dir     <= bulk_dir;
        bulk_cnt    <= '0;
        last_issued <= 1'b0;
      end

      // Only one dump byte is ever outstanding, so the sink taking a byte
      // after the final address was issued means the job is complete.
      if (sink_take) begin
        dump_valid <= 1'b0;
        if (last_issued) begin
          bulk_busy <= 1'b0;
          bulk_done <= 1'b1;
        end
      end

      case (state)
        S_GRANT: begin
          if (pick_host) begin
            last_was_bulk <= 1'b0;
            serve_bulk    <= 1'b0;
            if (host_oor) begin
              host_ack   <= 1'b1;
              host_err   <= 1'b1;
              host_rdata <= 8'h00;
            end else begin
              ext_eep_addr    <= host_addr;
              ext_eep_data_in <= host_wdata;
            end
          end else if (pick_bulk) begin
            last_was_bulk   <= 1'b1;
            serve_bulk      <= 1'b1;
            ext_eep_addr    <= 17'(bulk_cnt);
            ext_eep_data_in <= load_data;
            bulk_cnt        <= bulk_cnt + 1'b1;
            if (bulk_cnt == CNT_W'(EEP_SIZE - 1)) last_issued <= 1'b1;
            // The load byte is latched here; load_ready is seen during WR
            // so the source advances before the next GRANT samples it.
            if (job_dir) load_ready <= 1'b1;
          end
        end
        S_RD2: begin
          if (serve_bulk) begin
            dump_data  <= ext_eep_data_out;
            dump_valid <= 1'b1;
          end else begin
            host_rdata <= ext_eep_data_out;
            host_ack   <= 1'b1;
          end
        end
        S_WR: begin
          if (serve_bulk) begin
            if (last_issued) begin
              bulk_busy <= 1'b0;
              bulk_done <= 1'b1;
            end
          end else begin
            host_ack <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef EEP_ARB_CRC_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= 8'h00;
    end else if (bulk_start && !bulk_busy) begin
      crc <= 8'h00;
    end else if (state == S_WR && serve_bulk) begin
      crc <= crc8_step(crc, ext_eep_data_in);
    end else if (sink_take) begin
      crc <= crc8_step(crc, dump_data);
    end
  end

  assign bulk_crc = crc;
`else
  assign bulk_crc = 8'h00;
`endif

endmodule

// File: tb/tb_atmega_eep_arb.sv
// tb_atmega_eep_arb
//   Directed sequence with randomized data/addresses for atmega_eep_arb.
//   The bench owns the EEPROM array behind ext_eep_* and keeps a reference
//   image of what the array must contain; host reads, dump streams, restore
//   results and CRC values are predicted from that image.
module tb_atmega_eep_arb;

  localparam int N = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_req, host_we;
  logic [16:0] host_addr;
  logic [7:0]  host_wdata, host_rdata;
  logic        host_ack, host_err;
  logic        bulk_start, bulk_dir, bulk_busy, bulk_done;
  logic [7:0]  bulk_crc, dump_data, load_data;
  logic        dump_valid, dump_ready, load_valid, load_ready;
  logic        hold_req, hold_ack;
  logic [16:0] ext_eep_addr;
  logic [7:0]  ext_eep_data_in, ext_eep_data_out;
  logic        ext_eep_data_wr, ext_eep_data_rd, ext_eep_data_en;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [0:N-1];
  logic [7:0] ref_mem [0:N-1];
  logic [7:0] src     [0:N-1];
  logic [7:0] dq [$];

  int done_cnt = 0, ld_pops = 0, rd_cycles = 0, en_noack = 0, port_oor = 0;
  logic [2:0] hold_dly;
  logic [7:0] hreq_sr;
  logic sink_toggle, sink_level, feed_en;

  always #5 clk = ~clk;

  atmega_eep_arb #(.EEP_SIZE(N), .CNT_W(10)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .host_err(host_err),
    .bulk_start(bulk_start), .bulk_dir(bulk_dir), .bulk_busy(bulk_busy),
    .bulk_done(bulk_done), .bulk_crc(bulk_crc),
    .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .hold_req(hold_req), .hold_ack(hold_ack),
    .ext_eep_addr(ext_eep_addr), .ext_eep_data_in(ext_eep_data_in),
    .ext_eep_data_wr(ext_eep_data_wr), .ext_eep_data_rd(ext_eep_data_rd),
    .ext_eep_data_en(ext_eep_data_en), .ext_eep_data_out(ext_eep_data_out)
  );

  // Core park response: immediate, or hold_dly cycles late.
  always @(posedge clk) hreq_sr <= rst ? 8'h00 : {hreq_sr[6:0], hold_req};
  assign hold_ack = (hold_dly == 3'd0) ? hold_req : hreq_sr[hold_dly - 3'd1];

  // EEPROM behind the port: write on the strobe edge, read data one cycle late.
  always @(posedge clk) begin
    if (ext_eep_data_en && ext_eep_data_wr) begin
      if (ext_eep_addr < 17'(N)) mem[ext_eep_addr[8:0]] <= ext_eep_data_in;
      else port_oor <= port_oor + 1;
    end
    if (ext_eep_data_en && ext_eep_data_rd) begin
      if (ext_eep_addr < 17'(N)) ext_eep_data_out <= mem[ext_eep_addr[8:0]];
      else begin ext_eep_data_out <= 8'h00; port_oor <= port_oor + 1; end
    end
  end

  // Observers, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (dump_valid && dump_ready) dq.push_back(dump_data);
      if (bulk_done) done_cnt <= done_cnt + 1;
      if (load_ready) ld_pops <= ld_pops + 1;
      if (ext_eep_data_rd) rd_cycles <= rd_cycles + 1;
      if (ext_eep_data_en && !hold_ack) en_noack <= en_noack + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; afterwards refresh the stream sink/source inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    dump_ready = sink_toggle ? ~dump_ready : sink_level;
    load_valid = feed_en && (ld_pops < N);
    load_data  = (ld_pops < N) ? src[ld_pops] : 8'h00;
  endtask

  task automatic host_txn(input logic we, input logic [16:0] a, input logic [7:0] d,
                          output logic [7:0] rdata, output logic err, output int lat);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    lat = 0;
    do begin tick(); lat++; end while (!host_ack && lat < 200);
    rdata = host_rdata;
    err   = host_err;
    host_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic wait_done(input int d0, input int budget, output int used);
    used = 0;
    while (done_cnt == d0 && used < budget) begin tick(); used++; end
  endtask

  function automatic logic [7:0] crc8_of_src();
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < N; i++) begin
      c = c ^ src[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  initial begin
    logic [7:0] rd, v;
    logic       err;
    int         lat, used, d0, r0, p0, bad;
    logic [16:0] a;

    rst = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    bulk_start = 1'b0; bulk_dir = 1'b0; dump_ready = 1'b0; load_data = '0;
    load_valid = 1'b0; hold_dly = 3'd0; sink_toggle = 1'b0; sink_level = 1'b0;
    feed_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      v = 8'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
      src[i] = 8'($urandom);
    end
    repeat (3) tick();

    // Reset state
    chk("rst_hold_req", hold_req, 0);
    chk("rst_en", ext_eep_data_en, 0);
    chk("rst_busy", bulk_busy, 0);
    chk("rst_acks", {host_ack, host_err, bulk_done, dump_valid, load_ready}, 0);
    chk("rst_data", {host_rdata, dump_data, bulk_crc}, 0);
    chk("rst_addr", ext_eep_addr, 0);
    rst = 1'b0;
    tick();

    // Host write then read back
    host_txn(1'b1, 17'h005, 8'hA5, rd, err, lat);
    ref_mem[5] = 8'hA5;
    chk("wr_err", err, 0);
    chk("wr_lat", lat, 4);
    host_txn(1'b0, 17'h005, 8'h00, rd, err, lat);
    chk("rd_data", rd, 8'hA5);
    chk("rd_err", err, 0);
    chk("rd_lat", lat, 5);
    chk("rel_en", ext_eep_data_en, 0);
    chk("rel_hold_req", hold_req, 0);

    // Random host traffic
    for (int k = 0; k < 12; k++) begin
      a = 17'($urandom_range(0, N - 1));
      v = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        host_txn(1'b1, a, v, rd, err, lat);
        ref_mem[a[8:0]] = v;
        chk("rnd_wr_lat", lat, 4);
      end else begin
        host_txn(1'b0, a, v, rd, err, lat);
        chk("rnd_rd_data", rd, ref_mem[a[8:0]]);
        chk("rnd_rd_lat", lat, 5);
      end
      chk("rnd_err", err, 0);
    end

    // Out-of-range accesses never reach the port
    r0 = rd_cycles;
    host_txn(1'b0, 17'h200, 8'h00, rd, err, lat);
    chk("oor_rd_err", err, 1);
    chk("oor_rd_data", rd, 0);
    chk("oor_rd_lat", lat, 3);
    chk("oor_no_rd", rd_cycles - r0, 0);
    host_txn(1'b1, 17'($urandom_range(N, 17'h1FFFF)), 8'h5A, rd, err, lat);
    chk("oor_wr_err", err, 1);
    chk("oor_port", port_oor, 0);

    // Delayed park acknowledge
    hold_dly = 3'd4;
    repeat (10) tick();
    a = 17'($urandom_range(0, N - 1));
    host_txn(1'b0, a, 8'h00, rd, err, lat);
    chk("hold_rd_data", rd, ref_mem[a[8:0]]);
    chk("hold_lat", lat, 9);
    chk("hold_en_before_ack", en_noack, 0);
    repeat (10) tick();
    hold_dly = 3'd0;
    tick();

    // Dump with a toggling sink; a restart request mid-job is ignored
    dq.delete();
    sink_toggle = 1'b1;
    d0 = done_cnt;
    bulk_start = 1'b1; bulk_dir = 1'b0;
    tick();
    bulk_start = 1'b0;
    chk("dump_busy", bulk_busy, 1);
    repeat (100) tick();
    bulk_start = 1'b1; bulk_dir = 1'b1;
    tick();
    bulk_start = 1'b0; bulk_dir = 1'b0;
    wait_done(d0, 20000, used);
    chk("dump_timeout", used < 20000, 1);
    repeat (5) tick();
    sink_toggle = 1'b0; sink_level = 1'b0;
    chk("dump_count", dq.size(), N);
    bad = 0;
    for (int i = 0; i < N && i < dq.size(); i++) if (dq[i] !== ref_mem[i]) bad++;
    chk("dump_data_mismatches", bad, 0);
    chk("dump_done_pulses", done_cnt - d0, 1);
    chk("dump_busy_end", bulk_busy, 0);

    // Restore with a continuous source while the host reads
    feed_en = 1'b1;
    d0 = done_cnt;
    bulk_start = 1'b1; bulk_dir = 1'b1;
    tick();
    bulk_start = 1'b0; bulk_dir = 1'b0;
    repeat (10) tick();
    a = 17'($urandom_range(400, N - 1));
    p0 = ld_pops;
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    lat = 0;
    do begin tick(); lat++; end while (!host_ack && lat < 200);
    rd = host_rdata; err = host_err;
    host_req = 1'b0;
    chk("cont_rd_data", rd, ref_mem[a[8:0]]);
    chk("cont_lat_bound", lat <= 6, 1);
    chk("cont_bulk_bytes_between", (ld_pops - p0) <= 1, 1);
    wait_done(d0, 20000, used);
    chk("rest_timeout", used < 20000, 1);
`ifdef EEP_ARB_CRC_EN
    chk("rest_crc", bulk_crc, crc8_of_src());
`else
    chk("rest_crc_tied", bulk_crc, 0);
`endif
    repeat (5) tick();
    feed_en = 1'b0;
    for (int i = 0; i < N; i++) ref_mem[i] = src[i];
    chk("rest_pops", ld_pops, N);
    chk("rest_done_pulses", done_cnt - d0, 1);
    chk("rest_busy_end", bulk_busy, 0);
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("rest_mem_mismatches", bad, 0);
    chk("en_before_ack_total", en_noack, 0);

    // Reset in the middle of a dump
    sink_level = 1'b1;
    d0 = done_cnt;
    bulk_start = 1'b1; bulk_dir = 1'b0;
    tick();
    bulk_start = 1'b0;
    repeat (40) tick();
    chk("mid_busy", bulk_busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_ctrl", {hold_req, ext_eep_data_en, ext_eep_data_rd, ext_eep_data_wr}, 0);
    chk("mid_rst_flags", {host_ack, host_err, bulk_busy, bulk_done, dump_valid, load_ready}, 0);
    chk("mid_rst_data", {host_rdata, dump_data, bulk_crc}, 0);
    chk("mid_rst_addr", ext_eep_addr, 0);
    rst = 1'b0;
    repeat (1200) tick();
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_busy_after", bulk_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
